mult_rr_scheduler: RTL and testbench
====================================

Name: mult_rr_scheduler

Overview:
- Shares one pipelined 128x128 multiplier (`mult128`, instantiated outside this block) among NREQ requesters.
- Round-robin arbitration; at most one operation issued per cycle.
- Drives registered operands into the multiplier.
- Tracks in-flight operations with a tag pipeline and returns each 256-bit product to its originating requester as a one-cycle, one-hot valid pulse.

Parameters:
- NREQ, 4, number of requesters (2..8).
- W, 128, operand width; product width is 2*W.
- MULT_LAT, 1, external multiplier latency: operands on mul_a/mul_b in cycle c give a valid mul_result in cycle c+MULT_LAT (range 1..16).

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  NREQ  per-requester request.
- req_a  in  NREQ*W  operand A; requester i uses slice [i*W +: W].
- req_b  in  NREQ*W  operand B, same slicing.
- req_ready  out  NREQ  one-hot grant; accept = req_valid[i] & req_ready[i].
- mul_a  out  W  registered operand A to the multiplier.
- mul_b  out  W  registered operand B to the multiplier.
- mul_result  in  2*W  product from the multiplier.
- rsp_valid  out  NREQ  one-hot, one-cycle response pulse.
- rsp_data  out  2*W  registered product.
- inflight  out  5  count of accepted operations not yet responded.
- idle  out  1  high when inflight==0 and no req_valid is asserted.

Behaviour:
- Reset (reset==0, asynchronous): mul_a, mul_b, rsp_data = 0; rsp_valid = 0; tag pipe cleared; inflight = 0; RR pointer = NREQ-1, so requester 0 has first priority.
- In-flight operations are discarded on reset; no response is ever produced for them.
- Arbitration is combinational from req_valid and the RR pointer.
  - Search starts at pointer+1 modulo NREQ; the first asserted req_valid wins.
  - req_ready is one-hot or all-zero.
- Requesters must not make req_valid depend on req_ready.
- Request rules: a request, once asserted, holds valid and operands stable until accepted. Dropping it early is illegal; an assertion flags it.
- On accept by requester g in cycle t:
  - pointer <= g.
  - mul_a/mul_b <= that requester's operands (visible in t+1).
  - Tag stage 0 <= {valid=1, id=g}.
- No accept in a cycle: pointer unchanged; mul_a/mul_b hold their previous values; tag stage 0 valid = 0.
- Tag pipe depth is MULT_LAT+1 and shifts every cycle. The last stage aligns with mul_result validity, i.e. cycle t+1+MULT_LAT.
- Response: when the last tag stage is valid, then at the next edge rsp_data <= mul_result and rsp_valid <= onehot(id).
  - Otherwise rsp_valid <= 0 and rsp_data holds.
  - Total latency is accept cycle t to rsp_valid in cycle t+MULT_LAT+2.
- Throughput is 1 op/cycle; there is no response backpressure, and requesters must sink rsp_valid pulses.
- Responses come back in acceptance order.
- inflight: +1 on accept, -1 on rsp_valid; both in the same cycle leaves it unchanged.
  - Maximum value is MULT_LAT+2, so it never overflows.
- Single active requester: it is granted every cycle back-to-back.
- All active: strict rotation 0,1,..,NREQ-1,0. Rotation skips idle requesters with no bubble.
- Arithmetic is unsigned; widths are exact, with no truncation of the 2*W product.

Decomposition:
- Shared package: W, PW=2*W, IDW=$clog2(NREQ), INFW=5 constants; typedef tag_t {logic vld; logic [IDW-1:0] id;}.
- One sub-module, rr_arbiter (NREQ):
  - Inputs: req vector, pointer.
  - Output: one-hot grant plus encoded id.
  - Purely combinational.
  - Pointer register stays in the top level.
- Tag shift register and response register stay in the top level.

Test Plan (bench wraps a behavioural multiplier with MULT_LAT=1 and NREQ=4):
- Single op: req 2 with a=3, b=5 accepted at cycle 10 -> mul_a=3, mul_b=5 at cycle 11; rsp_valid=4'b0100 with rsp_data=15 at cycle 13; inflight goes 0,1,1,1,0.
- Contention: req_valid=4'b0011 at cycle 0 after reset -> grant 0 at cycle 0, then 1 at cycle 1; responses to 0 then 1 in cycles 3 and 4.
- Full load: all four valid for 8 cycles -> grants 0,1,2,3,0,1,2,3; eight responses in matching order; inflight peaks at 3; no bubbles.
- Skip idle: req_valid=4'b1001 with pointer=0 -> grant 3, then 0, then 3; requesters 1 and 2 never granted.
- Max operands: a=b=2^128-1 -> rsp_data = 2^256 - 2^129 + 1.
- Reset mid-flight: 3 ops accepted, reset pulsed low 1 cycle before the first response -> no rsp_valid afterwards; inflight=0; idle=1; mul_a=0; next grant goes to requester 0.

Source files
------------

// File: rtl/mult_rr_scheduler_pkg.sv
// Shared constants and types for the round-robin multiplier scheduler.
// The tag id is sized for the largest supported requester count so one tag_t serves every NREQ.
package mult_rr_scheduler_pkg;

  localparam int W        = 128;
  localparam int PW       = 2 * W;
  localparam int NREQ_MAX = 8;
  localparam int IDW      = $clog2(NREQ_MAX);
  localparam int INFW     = 5;

  typedef struct packed {
    logic           vld;
    logic [IDW-1:0] id;
  } tag_t;

endpackage

// File: rtl/mult_rr_scheduler_arbiter.sv
// Combinational round-robin arbiter: the search starts one past the last winner.
// The result is a one-hot grant plus the encoded winner id.
module rr_arbiter
  import mult_rr_scheduler_pkg::*;
#(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  gnt_id
);

  logic found;
  int   idx;

  always_comb begin
    grant  = '0;
    gnt_id = '0;
    found  = 1'b0;
    idx    = 0;
    for (int off = 1; off <= NREQ; off++) begin
      idx = (int'(ptr) + off) % NREQ;
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        gnt_id     = IDW'(idx);
      end
    end
  end

endmodule

// File: rtl/mult_rr_scheduler.sv
// Shares one external pipelined multiplier among NREQ requesters with round-robin issue,
// tracking each in-flight operation with a tag pipe so the product returns to its owner.
module mult_rr_scheduler
  import mult_rr_scheduler_pkg::*;
#(
  parameter int NREQ     = 4,
  parameter int MULT_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ*W-1:0] req_a,
  input  logic [NREQ*W-1:0] req_b,
  output logic [NREQ-1:0]   req_ready,
  output logic [W-1:0]      mul_a,
  output logic [W-1:0]      mul_b,
  input  logic [PW-1:0]     mul_result,
  output logic [NREQ-1:0]   rsp_valid,
  output logic [PW-1:0]     rsp_data,
  output logic [INFW-1:0]   inflight,
  output logic              idle
);

  logic [IDW-1:0] ptr;
  logic [IDW-1:0] gnt_id;
  logic           accept;
  tag_t           tag_q [0:MULT_LAT];

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req    (req_valid),
    .ptr    (ptr),
    .grant  (req_ready),
    .gnt_id (gnt_id)
  );

  // The grant is always a subset of req_valid, so any grant bit is an accept.
  assign accept = |req_ready;
  assign idle   = (inflight == '0) && !(|req_valid);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr   <= IDW'(NREQ - 1);
      mul_a <= '0;
      mul_b <= '0;
    end else if (accept) begin
      ptr   <= gnt_id;
      mul_a <= req_a[int'(gnt_id)*W +: W];
      mul_b <= req_b[int'(gnt_id)*W +: W];
    end
  end

  // The last tag stage lines up with the cycle in which mul_result is valid.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k <= MULT_LAT; k++) tag_q[k] <= '0;
    end else begin
      tag_q[0] <= '{vld: accept, id: gnt_id};
      for (int k = 1; k <= MULT_LAT; k++) tag_q[k] <= tag_q[k-1];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rsp_valid <= '0;
      rsp_data  <= '0;
    end else if (tag_q[MULT_LAT].vld) begin
      rsp_valid <= NREQ'(1) << tag_q[MULT_LAT].id;
      rsp_data  <= mul_result;
    end else begin
      rsp_valid <= '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      inflight <= '0;
    end else begin
      case ({accept, |rsp_valid})
        2'b10:   inflight <= inflight + INFW'(1);
        2'b01:   inflight <= inflight - INFW'(1);
        default: inflight <= inflight;
      endcase
    end
  end

  // A pending request must hold valid and operands until it is granted.
  for (genvar i = 0; i < NREQ; i++) begin : g_req_chk
    assert property (@(posedge clk) disable iff (!reset)
      (req_valid[i] && !req_ready[i]) |=>
        (req_valid[i] && $stable(req_a[i*W +: W]) && $stable(req_b[i*W +: W])))
      else $error("request %0d dropped or changed before grant", i);
  end

endmodule

// File: tb/tb_mult_rr_scheduler.sv
// Directed bench for mult_rr_scheduler with a one-cycle behavioural multiplier and four requesters.
module tb_mult_rr_scheduler;

  localparam int NREQ     = 4;
  localparam int MULT_LAT = 1;

  logic         clk = 1'b0;
  logic         reset;
  logic [3:0]   req_valid;
  logic [511:0] req_a;
  logic [511:0] req_b;
  logic [3:0]   req_ready;
  logic [127:0] mul_a;
  logic [127:0] mul_b;
  logic [255:0] mul_result;
  logic [3:0]   rsp_valid;
  logic [255:0] rsp_data;
  logic [4:0]   inflight;
  logic         idle;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  always_ff @(posedge clk) mul_result <= {128'd0, mul_a} * {128'd0, mul_b};

  mult_rr_scheduler #(.NREQ(NREQ), .MULT_LAT(MULT_LAT)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_ready  (req_ready),
    .mul_a      (mul_a),
    .mul_b      (mul_b),
    .mul_result (mul_result),
    .rsp_valid  (rsp_valid),
    .rsp_data   (rsp_data),
    .inflight   (inflight),
    .idle       (idle)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyReset();
    req_valid = '0;
    reset     = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  task automatic setOps(input int i, input logic [127:0] a, input logic [127:0] b);
    req_a[i*128 +: 128] = a;
    req_b[i*128 +: 128] = b;
  endtask

  task automatic applyStimulus(input logic [3:0] v);
    req_valid = v;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_assert++;
    assert (obs === exp)
      else begin
        n_fail++;
        $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
  endtask

  initial begin
    int           prod3 [4];
    logic [3:0]   pend;
    logic [127:0] ones;
    logic [255:0] maxprod;
    int           acc;
    int           rs;
    int           g;

    prod3   = '{200, 231, 264, 299};
    ones    = '1;
    maxprod = {{127{1'b1}}, 1'b0, {127{1'b0}}, 1'b1};

    reset     = 1'b1;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    #1;

    $display("[TB] reset state");
    applyReset();
    checkOutput("rst_mul_a", mul_a, 0);
    checkOutput("rst_mul_b", mul_b, 0);
    checkOutput("rst_rsp_data", rsp_data, 0);
    checkOutput("rst_rsp_valid", rsp_valid, 0);
    checkOutput("rst_inflight", inflight, 0);
    checkOutput("rst_idle", idle, 1);
    checkOutput("rst_ready", req_ready, 0);

    $display("[TB] single op on requester 2");
    setOps(2, 128'd3, 128'd5);
    repeat (10) tick();
    applyStimulus(4'b0100);
    checkOutput("t1_ready", req_ready, 4'b0100);
    checkOutput("t1_inf_c10", inflight, 0);
    tick();
    applyStimulus(4'b0000);
    checkOutput("t1_mul_a", mul_a, 3);
    checkOutput("t1_mul_b", mul_b, 5);
    checkOutput("t1_inf_c11", inflight, 1);
    checkOutput("t1_rsp_c11", rsp_valid, 0);
    tick();
    checkOutput("t1_inf_c12", inflight, 1);
    checkOutput("t1_rsp_c12", rsp_valid, 0);
    tick();
    checkOutput("t1_rsp_c13", rsp_valid, 4'b0100);
    checkOutput("t1_data_c13", rsp_data, 15);
    checkOutput("t1_inf_c13", inflight, 1);
    tick();
    checkOutput("t1_rsp_c14", rsp_valid, 0);
    checkOutput("t1_data_hold", rsp_data, 15);
    checkOutput("t1_inf_c14", inflight, 0);
    checkOutput("t1_idle", idle, 1);

    $display("[TB] contention between requesters 0 and 1");
    applyReset();
    setOps(0, 128'd7, 128'd9);
    setOps(1, 128'd100, 128'd200);
    applyStimulus(4'b0011);
    checkOutput("t2_ready_c0", req_ready, 4'b0001);
    tick();
    applyStimulus(4'b0010);
    checkOutput("t2_ready_c1", req_ready, 4'b0010);
    checkOutput("t2_mul_a_c1", mul_a, 7);
    tick();
    applyStimulus(4'b0000);
    checkOutput("t2_mul_a_c2", mul_a, 100);
    checkOutput("t2_mul_b_c2", mul_b, 200);
    checkOutput("t2_inf_c2", inflight, 2);
    tick();
    checkOutput("t2_rsp_c3", rsp_valid, 4'b0001);
    checkOutput("t2_data_c3", rsp_data, 63);
    tick();
    checkOutput("t2_rsp_c4", rsp_valid, 4'b0010);
    checkOutput("t2_data_c4", rsp_data, 20000);
    tick();
    checkOutput("t2_inf_c5", inflight, 0);

    $display("[TB] full load rotation");
    applyReset();
    for (int i = 0; i < 4; i++) setOps(i, 128'(10 + i), 128'(20 + i));
    pend = 4'hF;
    for (int c = 0; c < 12; c++) begin
      applyStimulus(pend);
      if (c < 8) checkOutput($sformatf("t3_ready_c%0d", c), req_ready, 4'b0001 << (c % 4));
      else       checkOutput($sformatf("t3_ready_c%0d", c), req_ready, 0);
      acc = (c < 8) ? c : 8;
      rs  = (c < 4) ? 0 : ((c - 3 > 8) ? 8 : c - 3);
      checkOutput($sformatf("t3_inf_c%0d", c), inflight, 256'(acc - rs));
      if (c >= 3 && c < 11) begin
        g = (c - 3) % 4;
        checkOutput($sformatf("t3_rsp_c%0d", c), rsp_valid, 4'b0001 << g);
        checkOutput($sformatf("t3_data_c%0d", c), rsp_data, 256'(prod3[g]));
      end else begin
        checkOutput($sformatf("t3_rsp_c%0d", c), rsp_valid, 0);
      end
      tick();
      if (c >= 4 && c < 8) pend[c % 4] = 1'b0;
    end

    $display("[TB] skip idle requesters");
    applyReset();
    setOps(0, 128'd2, 128'd3);
    setOps(3, 128'd4, 128'd5);
    applyStimulus(4'b1001);
    checkOutput("t4_ready_c0", req_ready, 4'b0001);
    tick();
    applyStimulus(4'b1001);
    checkOutput("t4_ready_c1", req_ready, 4'b1000);
    tick();
    applyStimulus(4'b1001);
    checkOutput("t4_ready_c2", req_ready, 4'b0001);
    tick();
    applyStimulus(4'b1001);
    checkOutput("t4_ready_c3", req_ready, 4'b1000);
    checkOutput("t4_rsp_c3", rsp_valid, 4'b0001);
    checkOutput("t4_data_c3", rsp_data, 6);
    tick();
    applyStimulus(4'b0001);
    checkOutput("t4_ready_c4", req_ready, 4'b0001);
    checkOutput("t4_rsp_c4", rsp_valid, 4'b1000);
    checkOutput("t4_data_c4", rsp_data, 20);
    tick();
    applyStimulus(4'b0000);
    repeat (5) tick();
    checkOutput("t4_inf_end", inflight, 0);
    checkOutput("t4_idle_end", idle, 1);

    $display("[TB] maximum operands");
    applyReset();
    setOps(1, ones, ones);
    applyStimulus(4'b0010);
    checkOutput("t5_ready", req_ready, 4'b0010);
    tick();
    applyStimulus(4'b0000);
    checkOutput("t5_mul_a", mul_a, 256'(ones));
    tick();
    tick();
    checkOutput("t5_rsp", rsp_valid, 4'b0010);
    checkOutput("t5_data", rsp_data, maxprod);
    tick();

    $display("[TB] reset while operations are in flight");
    applyReset();
    setOps(0, 128'd1, 128'd2);
    setOps(1, 128'd3, 128'd4);
    setOps(2, 128'd5, 128'd6);
    applyStimulus(4'b0111);
    checkOutput("t6_ready_c0", req_ready, 4'b0001);
    tick();
    applyStimulus(4'b0110);
    checkOutput("t6_ready_c1", req_ready, 4'b0010);
    tick();
    applyStimulus(4'b0100);
    checkOutput("t6_ready_c2", req_ready, 4'b0100);
    checkOutput("t6_inf_c2", inflight, 2);
    applyReset();
    checkOutput("t6_rsp_after", rsp_valid, 0);
    checkOutput("t6_inf_after", inflight, 0);
    checkOutput("t6_idle_after", idle, 1);
    checkOutput("t6_mul_a_after", mul_a, 0);
    checkOutput("t6_data_after", rsp_data, 0);
    for (int c = 0; c < 4; c++) begin
      tick();
      checkOutput($sformatf("t6_rsp_quiet_%0d", c), rsp_valid, 0);
      checkOutput($sformatf("t6_inf_quiet_%0d", c), inflight, 0);
    end
    applyStimulus(4'b0101);
    checkOutput("t6_next_grant", req_ready, 4'b0001);
    tick();
    applyStimulus(4'b0100);
    checkOutput("t6_second_grant", req_ready, 4'b0100);
    tick();
    applyStimulus(4'b0000);
    repeat (5) tick();
    checkOutput("t6_idle_end", idle, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
